// File: rtl/elevator_ctrl_n.sv
// ============================================================================
// elevator_ctrl_n : N-floor SCAN-order elevator controller with door timer
//                   and motor start/done handshake.            Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module elevator_ctrl_n #(
   parameter int NUM_FLOORS  = 4,
   parameter int FLOOR_W     = 4,
   parameter int DOOR_CYCLES = 200_000_000,
   parameter int HOME_FLOOR  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   input  logic [FLOOR_W-1:0]    req_floor_i,
   input  logic                  open_btn_i,
   input  logic                  close_btn_i,
   input  logic                  move_done_i,
   output logic                  move_start_o,
   output logic [FLOOR_W:0]      move_delta_o,
   output logic [FLOOR_W-1:0]    cur_floor_o,
   output logic [FLOOR_W-1:0]    tgt_floor_o,
   output logic                  dir_up_o,
   output logic                  door_open_o,
   output logic                  moving_o,
   output logic [NUM_FLOORS-1:0] pending_o,
   output logic                  req_err_o
);

   localparam int                 TMR_W    = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] HOME     = FLOOR_W'(HOME_FLOOR);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_OPEN   = 3'd1,
      S_SELECT = 3'd2,
      S_START  = 3'd3,
      S_MOVING = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [FLOOR_W-1:0]      cur_floor_q, cur_floor_d;
   logic [FLOOR_W-1:0]      tgt_floor_q, tgt_floor_d;
   logic                    dir_up_q, dir_up_d;
   logic                    door_open_q, door_open_d;
   logic                    moving_q, moving_d;
   logic                    move_start_q, move_start_d;
   logic [FLOOR_W:0]        move_delta_q, move_delta_d;
   logic [NUM_FLOORS-1:0]   pending_q, pending_d;
   logic                    req_err_q, req_err_d;
   logic [TMR_W-1:0]        timer_q, timer_d;

   logic [NUM_FLOORS-1:0]   w_req_hot, w_tgt_hot, w_cur_hot;
   logic                    w_req_in_range, w_req_ok, w_req_here;
   logic                    w_up_found, w_dn_found;
   logic [FLOOR_W-1:0]      w_up_floor, w_dn_floor;
   logic                    w_pick_found, w_pick_up;
   logic [FLOOR_W-1:0]      w_pick_floor;

   always_comb begin
      w_req_hot = '0;
      w_tgt_hot = '0;
      w_cur_hot = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         w_req_hot[i] = (int'(req_floor_i) == i);
         w_tgt_hot[i] = (int'(tgt_floor_q) == i);
         w_cur_hot[i] = (int'(cur_floor_q) == i);
      end
   end

   assign w_req_in_range = (int'(req_floor_i) < NUM_FLOORS);
   assign w_req_ok       = req_valid_i && w_req_in_range;
   // A call for the floor we are standing at is served by the door, not the bitmap.
   assign w_req_here     = w_req_ok && (req_floor_i == cur_floor_q) &&
                           ((state_q == S_IDLE) || (state_q == S_OPEN));

   // Nearest pending floor strictly above and strictly below the car.
   always_comb begin
      w_up_found = 1'b0;
      w_up_floor = '0;
      w_dn_found = 1'b0;
      w_dn_floor = '0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending_q[i] && (i > int'(cur_floor_q))) begin
            w_up_found = 1'b1;
            w_up_floor = FLOOR_W'(i);
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending_q[i] && (i < int'(cur_floor_q))) begin
            w_dn_found = 1'b1;
            w_dn_floor = FLOOR_W'(i);
         end
      end
   end

   always_comb begin
      w_pick_found = 1'b0;
      w_pick_up    = dir_up_q;
      w_pick_floor = cur_floor_q;
      if (dir_up_q ? w_up_found : w_dn_found) begin
         w_pick_found = 1'b1;
         w_pick_floor = dir_up_q ? w_up_floor : w_dn_floor;
      end else if (dir_up_q ? w_dn_found : w_up_found) begin
         w_pick_found = 1'b1;
         w_pick_up    = ~dir_up_q;
         w_pick_floor = dir_up_q ? w_dn_floor : w_up_floor;
      end
   end

   always_comb begin
      state_d      = state_q;
      cur_floor_d  = cur_floor_q;
      tgt_floor_d  = tgt_floor_q;
      dir_up_d     = dir_up_q;
      door_open_d  = door_open_q;
      moving_d     = moving_q;
      move_start_d = 1'b0;
      move_delta_d = move_delta_q;
      req_err_d    = req_valid_i && !w_req_in_range;
      timer_d      = timer_q;
      pending_d    = pending_q;
      if (w_req_ok && !w_req_here) begin
         pending_d = pending_q | w_req_hot;
      end

      case (state_q)
         S_IDLE: begin
            if (open_btn_i || w_req_here) begin
               state_d     = S_OPEN;
               door_open_d = 1'b1;
               timer_d     = TMR_LOAD;
            end else if (pending_q != '0) begin
               state_d = S_SELECT;
            end
         end
         S_OPEN: begin
            if (open_btn_i || w_req_here) begin
               timer_d = TMR_LOAD;
            end else if (close_btn_i || (timer_q == '0)) begin
               door_open_d = 1'b0;
               timer_d     = '0;
               state_d     = (pending_q != '0) ? S_SELECT : S_IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_SELECT: begin
            if (w_pick_found) begin
               tgt_floor_d  = w_pick_floor;
               dir_up_d     = w_pick_up;
               move_start_d = 1'b1;
               move_delta_d = {1'b0, w_pick_floor} - {1'b0, cur_floor_q};
               moving_d     = 1'b1;
               state_d      = S_START;
            end else begin
               // Only the current floor can remain here; drop it rather than spin.
               pending_d = pending_d & ~w_cur_hot;
               state_d   = S_IDLE;
            end
         end
         S_START: begin
            state_d = S_MOVING;
         end
         S_MOVING: begin
            door_open_d = 1'b0;
            if (move_done_i) begin
               cur_floor_d = tgt_floor_q;
               pending_d   = pending_d & ~w_tgt_hot;
               moving_d    = 1'b0;
               door_open_d = 1'b1;
               timer_d     = TMR_LOAD;
               state_d     = S_OPEN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cur_floor_q  <= HOME;
         tgt_floor_q  <= HOME;
         dir_up_q     <= 1'b1;
         door_open_q  <= 1'b0;
         moving_q     <= 1'b0;
         move_start_q <= 1'b0;
         move_delta_q <= '0;
         pending_q    <= '0;
         req_err_q    <= 1'b0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         cur_floor_q  <= cur_floor_d;
         tgt_floor_q  <= tgt_floor_d;
         dir_up_q     <= dir_up_d;
         door_open_q  <= door_open_d;
         moving_q     <= moving_d;
         move_start_q <= move_start_d;
         move_delta_q <= move_delta_d;
         pending_q    <= pending_d;
         req_err_q    <= req_err_d;
         timer_q      <= timer_d;
      end
   end

   assign move_start_o = move_start_q;
   assign move_delta_o = move_delta_q;
   assign cur_floor_o  = cur_floor_q;
   assign tgt_floor_o  = tgt_floor_q;
   assign dir_up_o     = dir_up_q;
   assign door_open_o  = door_open_q;
   assign moving_o     = moving_q;
   assign pending_o    = pending_q;
   assign req_err_o    = req_err_q;

endmodule

`default_nettype wire

// File: tb/tb_elevator_ctrl_n.sv
// ============================================================================
// tb_elevator_ctrl_n : vector-table bench for elevator_ctrl_n (4 floors,
//                      8-cycle door).                          Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_elevator_ctrl_n;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic [3:0] req_floor;
   logic       open_btn;
   logic       close_btn;
   logic       move_done;
   logic       move_start;
   logic [4:0] move_delta;
   logic [3:0] cur_floor;
   logic [3:0] tgt_floor;
   logic       dir_up;
   logic       door_open;
   logic       moving;
   logic [3:0] pending;
   logic       req_err;

   always #5 clk = ~clk;

   elevator_ctrl_n #(
      .NUM_FLOORS (4),
      .FLOOR_W    (4),
      .DOOR_CYCLES(8),
      .HOME_FLOOR (0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid),
      .req_floor_i (req_floor),
      .open_btn_i  (open_btn),
      .close_btn_i (close_btn),
      .move_done_i (move_done),
      .move_start_o(move_start),
      .move_delta_o(move_delta),
      .cur_floor_o (cur_floor),
      .tgt_floor_o (tgt_floor),
      .dir_up_o    (dir_up),
      .door_open_o (door_open),
      .moving_o    (moving),
      .pending_o   (pending),
      .req_err_o   (req_err)
   );

   // {move_start, move_delta, cur, tgt, dir_up, door_open, moving, pending, req_err}
   logic [21:0] act;
   assign act = {move_start, move_delta, cur_floor, tgt_floor, dir_up, door_open,
                 moving, pending, req_err};

   typedef struct {
      logic        rv;
      logic [3:0]  rf;
      logic        ob;
      logic        cb;
      logic        md;
      int          reps;
      logic [21:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic rv, input logic [3:0] rf, input logic ob,
                      input logic cb, input logic md, input int reps,
                      input logic ms, input logic [4:0] dl, input logic [3:0] cur,
                      input logic [3:0] tgt, input logic dir, input logic door,
                      input logic mov, input logic [3:0] pend, input logic err);
      vec_t v;
      v.rv   = rv;
      v.rf   = rf;
      v.ob   = ob;
      v.cb   = cb;
      v.md   = md;
      v.reps = reps;
      v.exp  = {ms, dl, cur, tgt, dir, door, mov, pend, err};
      tbl.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic found;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_floor = 4'd0;
      open_btn  = 1'b0;
      close_btn = 1'b0;
      move_done = 1'b0;

      //   rv rf ob cb md reps  ms dl       cur tgt dir door mov pend     err
      add(1, 2, 0, 0, 0, 1,    0, 0,        0,  0,  1,  0,   0,  4'b0100, 0); // request floor 2
      add(0, 0, 0, 0, 0, 1,    0, 0,        0,  0,  1,  0,   0,  4'b0100, 0); // -> select
      add(0, 0, 0, 0, 0, 1,    1, 2,        0,  2,  1,  0,   1,  4'b0100, 0); // start +2
      add(0, 0, 0, 0, 0, 1,    0, 2,        0,  2,  1,  0,   1,  4'b0100, 0);
      add(0, 0, 1, 0, 0, 1,    0, 2,        0,  2,  1,  0,   1,  4'b0100, 0); // open_btn ignored
      add(0, 0, 0, 0, 1, 1,    0, 2,        2,  2,  1,  1,   0,  4'b0000, 0); // arrive floor 2
      add(0, 0, 0, 0, 0, 7,    0, 2,        2,  2,  1,  1,   0,  4'b0000, 0); // dwell
      add(0, 0, 0, 0, 0, 1,    0, 2,        2,  2,  1,  0,   0,  4'b0000, 0); // closes after 8
      add(1, 5, 0, 0, 0, 1,    0, 2,        2,  2,  1,  0,   0,  4'b0000, 1); // out of range
      add(0, 0, 0, 0, 1, 1,    0, 2,        2,  2,  1,  0,   0,  4'b0000, 0); // stray move_done
      add(1, 2, 0, 0, 0, 1,    0, 2,        2,  2,  1,  1,   0,  4'b0000, 0); // call at cur floor
      add(0, 0, 0, 1, 0, 1,    0, 2,        2,  2,  1,  0,   0,  4'b0000, 0); // close
      add(1, 0, 0, 0, 0, 1,    0, 2,        2,  2,  1,  0,   0,  4'b0001, 0); // req 0
      add(1, 3, 0, 0, 0, 1,    0, 2,        2,  2,  1,  0,   0,  4'b1001, 0); // req 3
      add(0, 0, 0, 0, 0, 1,    1, 1,        2,  3,  1,  0,   1,  4'b1001, 0); // up first: 3
      add(0, 0, 0, 0, 0, 1,    0, 1,        2,  3,  1,  0,   1,  4'b1001, 0);
      add(0, 0, 0, 0, 1, 1,    0, 1,        3,  3,  1,  1,   0,  4'b0001, 0); // at 3
      add(0, 0, 0, 1, 0, 1,    0, 1,        3,  3,  1,  0,   0,  4'b0001, 0);
      add(0, 0, 0, 0, 0, 1,    1, 5'b11101, 3,  0,  0,  0,   1,  4'b0001, 0); // reverse: -3
      add(1, 1, 0, 0, 0, 1,    0, 5'b11101, 3,  0,  0,  0,   1,  4'b0011, 0); // req 1 en route
      add(0, 0, 0, 0, 1, 1,    0, 5'b11101, 0,  0,  0,  1,   0,  4'b0010, 0); // at 0
      add(0, 0, 0, 1, 0, 1,    0, 5'b11101, 0,  0,  0,  0,   0,  4'b0010, 0);
      add(0, 0, 0, 0, 0, 1,    1, 1,        0,  1,  1,  0,   1,  4'b0010, 0); // reverse: +1
      add(0, 0, 0, 0, 0, 1,    0, 1,        0,  1,  1,  0,   1,  4'b0010, 0);
      add(1, 1, 0, 0, 1, 1,    0, 1,        1,  1,  1,  1,   0,  4'b0000, 0); // req tgt + done
      add(0, 0, 0, 0, 0, 2,    0, 1,        1,  1,  1,  1,   0,  4'b0000, 0); // timer -> 5
      add(0, 0, 0, 1, 0, 1,    0, 1,        1,  1,  1,  0,   0,  4'b0000, 0); // close at 5
      add(0, 0, 1, 0, 0, 20,   0, 1,        1,  1,  1,  1,   0,  4'b0000, 0); // open held
      add(0, 0, 0, 0, 0, 7,    0, 1,        1,  1,  1,  1,   0,  4'b0000, 0);
      add(0, 0, 0, 0, 0, 1,    0, 1,        1,  1,  1,  0,   0,  4'b0000, 0); // 8 after release
      add(1, 3, 0, 0, 0, 1,    0, 1,        1,  1,  1,  0,   0,  4'b1000, 0);
      add(0, 0, 0, 0, 0, 1,    0, 1,        1,  1,  1,  0,   0,  4'b1000, 0);
      add(0, 0, 0, 0, 0, 1,    1, 2,        1,  3,  1,  0,   1,  4'b1000, 0);
      add(1, 1, 0, 0, 0, 1,    0, 2,        1,  3,  1,  0,   1,  4'b1010, 0); // old floor while moving
      add(0, 0, 0, 0, 0, 1,    0, 2,        1,  3,  1,  0,   1,  4'b1010, 0);

      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (act !== 22'b0_00000_0000_0000_1_0_0_0000_0) begin
         errors++;
         $display("FAIL reset_state: got %b want %b", act, 22'b0_00000_0000_0000_1_0_0_0000_0);
      end
      rst_n = 1'b1;

      foreach (tbl[k]) begin
         for (int r = 0; r < tbl[k].reps; r++) begin
            req_valid = tbl[k].rv;
            req_floor = tbl[k].rf;
            open_btn  = tbl[k].ob;
            close_btn = tbl[k].cb;
            move_done = tbl[k].md;
            @(posedge clk);
            #1;
            checks++;
            if (act !== tbl[k].exp) begin
               errors++;
               $display("FAIL vec%0d rep%0d: got %b want %b", k, r, act, tbl[k].exp);
            end
         end
      end

      // Asynchronous reset while moving with pending = 1010.
      req_valid = 1'b0;
      req_floor = 4'd0;
      open_btn  = 1'b0;
      close_btn = 1'b0;
      move_done = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (act !== 22'b0_00000_0000_0000_1_0_0_0000_0) begin
         errors++;
         $display("FAIL async_reset: got %b want %b", act, 22'b0_00000_0000_0000_1_0_0_0000_0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (move_start !== 1'b0 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_quiet cyc%0d: got start=%b pend=%b want start=0 pend=0000",
                     c, move_start, pending);
         end
      end

      // A fresh request must start a move of +2 within a bounded number of cycles.
      req_valid = 1'b1;
      req_floor = 4'd2;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      found     = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (move_start === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (!found || move_delta !== 5'd2) begin
         errors++;
         $display("FAIL restart_move: got found=%b delta=%b want found=1 delta=00010",
                  found, move_delta);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
